cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling engine between one cache (instruction or data) and the shared pipelined 4-cycle main memory. On a cache miss it fetches the whole 16-byte block containing the miss address, one 16-bit word per memory request. It streams returned words into the cache data array and writes the tag array on the final word. The cache arbiter instantiates one copy per cache and gates memory access with a per-FSM grant.

## Interface
Parameters:
- BLOCK_WORDS, 8 — 16-bit words per cache block; power of two.
- MEM_LATENCY, 4 — cycles from request issue to the matching memory_data_valid; used only for the timeout default and the test plan.
- TIMEOUT_CYCLES, 32 — max cycles between consecutive responses before abort; present only with the macro.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  16  byte address of the missing access
- mem_grant  in  1  arbiter allows this FSM to issue a request this cycle
- memory_data  in  16  word returned by main memory
- memory_data_valid  in  1  memory_data carries a response for this FSM
- fsm_busy  out  1  fill in progress; the pipeline stalls on it
- mem_req  out  1  request issued this cycle
- memory_address  out  16  request byte address
- write_data_array  out  1  write fill_data at fill_address into the data array
- write_tag_array  out  1  write the tag for the block at fill_address
- fill_address  out  16  byte address of the word being written
- fill_data  out  16  word being written; equals memory_data
- fill_error  out  1  one-cycle abort pulse; tied to 0 without the macro

## Operation
- States: IDLE and FILL. Reset value of every output is 0. Reset value of the state is IDLE.
- IDLE to FILL happens when miss_detected=1. On that edge the FSM latches base = {miss_address[15:4], 4'h0}, clears req_cnt and rsp_cnt, and clears the timeout counter.
- FILL behaviour:
  - fsm_busy=1 for the whole state.
  - mem_req = mem_grant & (req_cnt < BLOCK_WORDS).
  - memory_address = base + 2*req_cnt (16-bit arithmetic, no carry out).
  - req_cnt increments only on cycles with mem_req=1.
- Response path:
  - write_data_array = FILL & memory_data_valid.
  - fill_address = base + 2*rsp_cnt. fill_data = memory_data.
  - rsp_cnt increments on each valid. Responses arrive in request order.
- Final word: on the valid with rsp_cnt = BLOCK_WORDS-1, write_tag_array=1 in the same cycle, and the next state is IDLE.
- In IDLE:
  - miss_detected is acted on only in IDLE; while in FILL it is ignored.
  - memory_data_valid is ignored in IDLE, and no write strobe is raised.
- Counters are log2(BLOCK_WORDS)+1 bits wide, so req_cnt can reach BLOCK_WORDS and stop.
- Reset asserted mid-fill: immediate return to IDLE, all outputs 0, no tag write. Any responses still in flight after reset releases are ignored.
- Grant dropped mid-fill: request issue pauses. Responses already issued are still accepted.

## Timing
- Miss sampled at edge 0. fsm_busy is high from cycle 1.
- With continuous grant: requests in cycles 1..8, responses in cycles 1+MEM_LATENCY .. 8+MEM_LATENCY (5..12 for the defaults).
- write_tag_array is high in cycle 12. fsm_busy falls in cycle 13.
- Fill latency is BLOCK_WORDS + MEM_LATENCY cycles plus the number of grant-low cycles.
- A new miss can be accepted in the first IDLE cycle (back-to-back fills).
- All outputs are registered state or combinational from registered state plus memory_data, memory_data_valid and mem_grant. There is no combinational path from miss_detected to any output.

## Configuration
- CACHE_FILL_TIMEOUT_EN defined:
  - A counter clears on entry to FILL and on every accepted response, and increments on every other FILL cycle.
  - When it reaches TIMEOUT_CYCLES: fill_error pulses for one cycle, the state returns to IDLE, and there is no tag write.
  - Data words already written remain, but the block stays invalid.
- CACHE_FILL_TIMEOUT_EN undefined: no counter and no TIMEOUT_CYCLES logic; fill_error is tied to 0; FILL waits indefinitely.

## Structure
- Shared package cache_pkg holds:
  - the fill_state_t enum (IDLE, FILL)
  - BLOCK_BYTES=16
  - the offset width constant
  - the block-base mask helper
  The data cache, instruction cache and arbiter use these same definitions.
- Single module. No sub-module: the counters and the next-state logic are too small to split.

## Test plan
- Miss at 0x1234, grant always 1, latency 4:
  - mem_req in cycles 1..8 with addresses 0x1230..0x123E step 2.
  - write_data_array in cycles 5..12 with fill_address 0x1230..0x123E.
  - write_tag_array only in cycle 12.
  - fsm_busy high for cycles 1..12.
- Grant low in cycles 3–5 of a fill at 0x0040:
  - No mem_req in those cycles. Request addresses are still contiguous 0x0040..0x004E.
  - Tag write is delayed by 3 cycles, to cycle 15.
- Miss reasserted in every cycle of a fill: ignored, with exactly one tag write. A second miss at 0x0100 in the first IDLE cycle starts a new fill from base 0x0100.
- rst_n low in cycle 6 of a fill:
  - All outputs go to 0 immediately.
  - After release, stray memory_data_valid pulses produce no write_data_array.
- Miss address 0xFFF6: base 0xFFF0, last request 0xFFFE, with no wrap into 0x0000.
- With CACHE_FILL_TIMEOUT_EN and TIMEOUT_CYCLES=32, a fill whose third response never arrives gives a fill_error pulse 32 cycles after the second response, a return to IDLE, and no write_tag_array.

Source files
------------

// File: rtl/cache_pkg.sv
// Definitions shared by the data cache, instruction cache, arbiter and the fill FSM:
// fill-state encoding, block geometry and the block-base mask helper.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES);

    // Byte address of the first byte of the block containing addr.
    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & ~16'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/fill/memory signal bundle of one cache fill FSM.
// master = the fill FSM, slave = the cache, arbiter and memory side.
interface cache_fill_fsm_if;

    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_grant;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] fill_address;
    logic [15:0] fill_data;
    logic        fill_error;

    modport master (
        input  miss_detected, miss_address, mem_grant, memory_data, memory_data_valid,
        output fsm_busy, mem_req, memory_address, write_data_array, write_tag_array,
               fill_address, fill_data, fill_error
    );

    modport slave (
        output miss_detected, miss_address, mem_grant, memory_data, memory_data_valid,
        input  fsm_busy, mem_req, memory_address, write_data_array, write_tag_array,
               fill_address, fill_data, fill_error
    );

endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one block word-by-word from pipelined main memory.
// Optional response timeout/abort is enabled by defining CACHE_FILL_TIMEOUT_EN.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4
`ifdef CACHE_FILL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 8 * MEM_LATENCY
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_fill_fsm_if.master bus
);

    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    // The block base mask assumes 16-bit words filling exactly one BLOCK_BYTES block.
    generate
        if (BLOCK_WORDS * 2 != BLOCK_BYTES || MEM_LATENCY < 1) begin : g_param_check
            $error("cache_fill_fsm: BLOCK_WORDS must match BLOCK_BYTES/2 and MEM_LATENCY >= 1");
        end
    endgenerate

    fill_state_t      state_reg;
    logic [15:0]      base_reg;
    logic [CNT_W-1:0] req_cnt_reg;
    logic [CNT_W-1:0] rsp_cnt_reg;

    logic in_fill;
    logic issue;
    logic accept;
    logic timed_out;

    assign in_fill = (state_reg == FILL);
    assign issue   = in_fill & bus.mem_grant & (req_cnt_reg < ALL_WORDS);
    assign accept  = in_fill & bus.memory_data_valid;

`ifdef CACHE_FILL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;

    // Fires on the cycle the silent-cycle count would reach TIMEOUT_CYCLES.
    assign timed_out = in_fill & ~bus.memory_data_valid & (tmo_cnt_reg == TMO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    assign bus.fsm_busy         = in_fill;
    assign bus.mem_req          = issue;
    assign bus.memory_address   = in_fill ? base_reg + (16'(req_cnt_reg) << 1) : '0;
    assign bus.write_data_array = accept;
    assign bus.write_tag_array  = accept & (rsp_cnt_reg == LAST_WORD);
    assign bus.fill_address     = in_fill ? base_reg + (16'(rsp_cnt_reg) << 1) : '0;
    assign bus.fill_data        = in_fill ? bus.memory_data : '0;
    assign bus.fill_error       = timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            base_reg    <= '0;
            req_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
`ifdef CACHE_FILL_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.miss_detected) begin
                        state_reg   <= FILL;
                        base_reg    <= block_base(bus.miss_address);
                        req_cnt_reg <= '0;
                        rsp_cnt_reg <= '0;
`ifdef CACHE_FILL_TIMEOUT_EN
                        tmo_cnt_reg <= '0;
`endif
                    end
                end
                FILL: begin
                    if (issue) begin
                        req_cnt_reg <= req_cnt_reg + CNT_W'(1);
                    end
                    // Responses return in request order, so rsp_cnt alone tracks the word.
                    if (accept) begin
                        rsp_cnt_reg <= rsp_cnt_reg + CNT_W'(1);
                        if (rsp_cnt_reg == LAST_WORD) begin
                            state_reg <= IDLE;
                        end
                    end
`ifdef CACHE_FILL_TIMEOUT_EN
                    if (accept) begin
                        tmo_cnt_reg <= '0;
                    end else if (timed_out) begin
                        state_reg <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed fill scenarios plus random traffic
// against a queue-based model of block fills and a fixed-latency memory.
module tb_cache_fill_fsm;

    localparam int BW  = 8;
    localparam int LAT = 4;
    localparam int TMO = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cache_fill_fsm_if bus();

    cache_fill_fsm #(
        .BLOCK_WORDS(BW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: a fill is a list of word addresses still to request and a list awaiting data.
    bit          m_busy = 0;
    logic [15:0] q_req[$];
    logic [15:0] q_rsp[$];
    int          done   = 0;
    int          run    = 0;
    int          issued = 0;
    bit          drop_mode = 0;
    int          due_q[$];
    logic [15:0] dat_q[$];

    int          tag_seen      = 0;
    int          last_tag_rel  = -1;
    int          miss_cyc      = 0;
    int          last_rsp_cyc  = 0;
    int          err_rel       = -1;
    logic [15:0] last_req_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},     32'(bus.fsm_busy), 0);
        check({pfx, "_mem_req"},  32'(bus.mem_req), 0);
        check({pfx, "_mem_addr"}, 32'(bus.memory_address), 0);
        check({pfx, "_wr_data"},  32'(bus.write_data_array), 0);
        check({pfx, "_wr_tag"},   32'(bus.write_tag_array), 0);
        check({pfx, "_f_addr"},   32'(bus.fill_address), 0);
        check({pfx, "_f_data"},   32'(bus.fill_data), 0);
        check({pfx, "_error"},    32'(bus.fill_error), 0);
    endtask

    task automatic start_fill(input logic [15:0] addr);
        logic [15:0] base;
        base = addr - (addr % 16'd16);
        m_busy = 1;
        q_req.delete();
        q_rsp.delete();
        for (int k = 0; k < BW; k++) q_req.push_back(base + 16'(2 * k));
        done     = 0;
        run      = 0;
        issued   = 0;
        miss_cyc = cyc;
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance model over the edge.
    task automatic step(input bit miss, input logic [15:0] addr, input bit grant, input bit stray);
        bit          v;
        logic [15:0] d;
        bit          e_req, e_wr, e_tag, e_err;
        v = 0;
        d = 16'($urandom);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            v = 1;
            d = dat_q.pop_front();
            void'(due_q.pop_front());
        end else if (!m_busy && stray && $urandom_range(0, 1) == 1) begin
            v = 1;
        end
        bus.miss_detected     = miss;
        bus.miss_address      = addr;
        bus.mem_grant         = grant;
        bus.memory_data       = d;
        bus.memory_data_valid = v;
        #4;
        e_req = m_busy && grant && q_req.size() > 0;
        e_wr  = m_busy && v;
        e_tag = e_wr && (done == BW - 1);
        e_err = 0;
`ifdef CACHE_FILL_TIMEOUT_EN
        e_err = m_busy && !v && (run == TMO - 1);
`endif
        check("busy", 32'(bus.fsm_busy), 32'(m_busy));
        check("mem_req", 32'(bus.mem_req), 32'(e_req));
        if (e_req) check("mem_addr", 32'(bus.memory_address), 32'(q_req[0]));
        check("wr_data", 32'(bus.write_data_array), 32'(e_wr));
        if (e_wr && q_rsp.size() > 0) begin
            check("fill_addr", 32'(bus.fill_address), 32'(q_rsp[0]));
            check("fill_data", 32'(bus.fill_data), 32'(d));
        end
        check("wr_tag", 32'(bus.write_tag_array), 32'(e_tag));
        check("fill_error", 32'(bus.fill_error), 32'(e_err));
        if (bus.mem_req) last_req_addr = bus.memory_address;
        if (bus.write_tag_array) begin
            tag_seen++;
            last_tag_rel = cyc - miss_cyc;
            $display("fill done: tag addr=%04h cycle=%0d latency=%0d", bus.fill_address, cyc, last_tag_rel);
        end
        if (bus.fill_error) begin
            err_rel = cyc - last_rsp_cyc;
            $display("fill abort: cycle=%0d since_last_rsp=%0d", cyc, err_rel);
        end
        if (m_busy) begin
            if (e_req) begin
                if (!(drop_mode && issued >= 2)) begin
                    due_q.push_back(cyc + LAT);
                    dat_q.push_back(16'($urandom));
                end
                q_rsp.push_back(q_req.pop_front());
                issued++;
            end
            if (e_wr) begin
                if (q_rsp.size() > 0) void'(q_rsp.pop_front());
                done++;
                run = 0;
                last_rsp_cyc = cyc;
                if (done == BW) m_busy = 0;
            end else begin
                if (e_err) m_busy = 0;
                run++;
            end
        end else if (miss) begin
            start_fill(addr);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 1, 1);
    endtask

    task automatic reset_mid_fill();
        bus.miss_detected     = 1;
        bus.miss_address      = 16'h0ABC;
        bus.mem_grant         = 1;
        bus.memory_data       = 16'hA5A5;
        bus.memory_data_valid = 1;
        rst_n = 0;
        #1;
        check_all_zero("midrst");
        m_busy = 0;
        q_req.delete();
        q_rsp.delete();
        @(posedge clk);
        #1;
        cyc++;
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        rst_n = 1;
    endtask

    initial begin
        int tags_before;
        bus.miss_detected     = 1;
        bus.miss_address      = 16'h1234;
        bus.mem_grant         = 1;
        bus.memory_data       = 16'hFFFF;
        bus.memory_data_valid = 1;
        #1 rst_n = 0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc = 0;

        // Basic fill at 0x1234, continuous grant.
        tag_seen = 0;
        step(1, 16'h1234, 1, 0);
        for (int i = 0; i < 14; i++) step(0, 16'h0, 1, 0);
        check("t1_tag_cycle", 32'(last_tag_rel), 32'd12);
        check("t1_tag_count", 32'(tag_seen), 32'd1);

        // Grant low in cycles 3..5 delays the tag write to cycle 15.
        step(1, 16'h0040, 1, 0);
        for (int i = 1; i <= 18; i++) step(0, 16'h0, !(i >= 3 && i <= 5), 0);
        check("t2_tag_cycle", 32'(last_tag_rel), 32'd15);

        // Miss held through a fill, then a back-to-back miss in the first IDLE cycle.
        tag_seen = 0;
        step(1, 16'h0200, 1, 0);
        for (int i = 1; i <= 12; i++) step(1, 16'($urandom), 1, 0);
        check("t3_single_tag", 32'(tag_seen), 32'd1);
        step(1, 16'h0100, 1, 0);
        for (int i = 0; i < 14; i++) step(0, 16'h0, 1, 0);
        check("t3_b2b_tags", 32'(tag_seen), 32'd2);
        check("t3_b2b_tag_cycle", 32'(last_tag_rel), 32'd12);

        // Reset in cycle 6 of a fill; stray responses afterwards must be ignored.
        tags_before = tag_seen;
        step(1, 16'h0300, 1, 0);
        for (int i = 1; i <= 5; i++) step(0, 16'h0, 1, 0);
        reset_mid_fill();
        idle(10);
        check("t4_no_tag", 32'(tag_seen), 32'(tags_before));

        // Top-of-memory block: no wrap past 0xFFFE.
        step(1, 16'hFFF6, 1, 0);
        for (int i = 0; i < 14; i++) step(0, 16'h0, 1, 0);
        check("t5_last_req", 32'(last_req_addr), 32'hFFFE);
        check("t5_tag_cycle", 32'(last_tag_rel), 32'd12);

        // Random misses, addresses, grants and stray responses while idle.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) != 0, 1);
        end
        for (int i = 0; i < 200 && m_busy; i++) step(0, 16'h0, 1, 0);
        check("drain_idle", 32'(bus.fsm_busy), 32'd0);
        idle(LAT + 2);

`ifdef CACHE_FILL_TIMEOUT_EN
        // Responses from the third onward are lost: abort 32 cycles after the second.
        tags_before = tag_seen;
        drop_mode = 1;
        step(1, 16'h0500, 1, 0);
        for (int i = 0; i < 45; i++) step(0, 16'h0, 1, 0);
        drop_mode = 0;
        check("t6_err_delay", 32'(err_rel), 32'(TMO));
        check("t6_no_tag", 32'(tag_seen), 32'(tags_before));
        check("t6_idle", 32'(bus.fsm_busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
